gate_truth_checker: RTL

Self-checking truth-table sequencer for the project-1 combinational gates, e.g. student_or.
- Drives every input combination into the gate under test and samples the gate's output after a settle delay.
- Compares each sample against a parameterised expected truth table and reports a pass/fail summary.
- Turns the printed truth-table check into a clocked, synthesizable stage that feeds the gate and consumes its output.

---
 rtl/gate_truth_checker.sv | 112 +++++++++++
 1 files changed

// File: rtl/gate_truth_checker.sv
// Truth-table sweeper for a combinational gate under test.
// Walks every input combination, holds each for a settle window, samples the
// gate output and tallies mismatches against the EXPECTED table.
module gate_truth_checker #(
    parameter int unsigned                N_INPUTS      = 2,
    parameter logic [(2**N_INPUTS)-1:0]   EXPECTED      = 4'b1110,
    parameter int unsigned                SETTLE_CYCLES = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                dut_out,
    output logic [N_INPUTS-1:0] stim,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [N_INPUTS:0]   err_count,
    output logic [N_INPUTS-1:0] first_fail,
    output logic                sample_valid,
    output logic                sample_match
);

    localparam int unsigned CntW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam logic [CntW-1:0]     SettleInit = CntW'(SETTLE_CYCLES);
    localparam logic [N_INPUTS-1:0] LastIdx    = '1;

    typedef enum logic [1:0] {StIdle, StSettle, StSample, StDone} state_e;

    state_e                state_q;
    logic [N_INPUTS-1:0]   idx_q;
    logic [CntW-1:0]       cnt_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  pass_q;
    logic [N_INPUTS:0]     err_q;
    logic [N_INPUTS-1:0]   first_fail_q;
    logic                  match;

    // Compare the live gate output with the table entry for the current vector.
    // Case equality so an X/Z from the gate is scored as a mismatch.
    always_comb begin
        match        = (dut_out === EXPECTED[idx_q]);
        sample_valid = (state_q == StSample);
        sample_match = (state_q == StSample) && match;
    end

    // Sweep sequencer: accept start, settle each vector, sample, tally results.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            cnt_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_q        <= '0;
            first_fail_q <= '0;
        end else begin
            case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        idx_q        <= '0;
                        err_q        <= '0;
                        first_fail_q <= '0;
                        done_q       <= 1'b0;
                        pass_q       <= 1'b0;
                        cnt_q        <= SettleInit;
                        busy_q       <= 1'b1;
                        state_q      <= StSettle;
                    end
                end
                StSettle: begin
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CntW'(1)) begin
                        state_q <= StSample;
                    end
                end
                StSample: begin
                    if (!match) begin
                        err_q <= err_q + 1'b1;
                        // Only the first mismatch of the sweep is recorded.
                        if (err_q == '0) begin
                            first_fail_q <= idx_q;
                        end
                    end
                    if (idx_q == LastIdx) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= match && (err_q == '0);
                        state_q <= StDone;
                    end else begin
                        idx_q   <= idx_q + 1'b1;
                        cnt_q   <= SettleInit;
                        state_q <= StSettle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // idx stays 0 in IDLE and holds the last vector in DONE, so it drives stim directly.
    always_comb begin
        stim       = idx_q;
        busy       = busy_q;
        done       = done_q;
        pass       = pass_q;
        err_count  = err_q;
        first_fail = first_fail_q;
    end

endmodule
